// File: rtl/uart_access_arbiter.sv
// uart_access_arbiter: round-robin sharing of one uartAccess byte engine among NUM_REQ requesters.
// Define UART_ARB_LOCK_EN to let a requester hold its grant across a multi-byte burst via reqLock.
module uart_access_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [NUM_REQ-1:0]   reqRnW,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqTimeOutEn,
  input  logic [NUM_REQ-1:0]   reqLock,
  output logic [NUM_REQ-1:0]   reqDone,
  output logic [7:0]           rdData,
  output logic                 rdTimeOut,
  output logic [IDX_W-1:0]     grantIdx,
  output logic                 accessReq,
  output logic                 readNotWrite,
  output logic [7:0]           dataIn,
  output logic                 timeOutEnable,
  input  logic                 busy,
  input  logic [7:0]           dataOut,
  input  logic                 timeOut
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WT_BUSY_LO = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic                 access_req_q;
  logic                 rnw_q;
  logic [7:0]           data_in_q;
  logic                 toen_q;
  logic [7:0]           rd_data_q;
  logic                 rd_to_q;
  logic [NUM_REQ-1:0]   req_done_q;

  logic                 win_vld_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic [IDX_W:0]       cand_d;

  // Scan farthest-to-nearest so the nearest valid slot after rr_ptr_q is the one kept.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand_d    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_d = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand_d >= (IDX_W+1)'(NUM_REQ)) begin
        cand_d = cand_d - (IDX_W+1)'(NUM_REQ);
      end
      if (reqValid[cand_d[IDX_W-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d[IDX_W-1:0];
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic [IDX_W-1:0] lock_ptr_d;
  // Pointing one slot behind the holder makes it the first candidate next IDLE.
  assign lock_ptr_d = (grant_idx_q == '0) ? IDX_W'(NUM_REQ - 1) : grant_idx_q - IDX_W'(1);
`else
  logic unused_lock;
  assign unused_lock = ^reqLock;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_idx_q  <= '0;
      access_req_q <= 1'b0;
      rnw_q        <= 1'b0;
      data_in_q    <= '0;
      toen_q       <= 1'b0;
      rd_data_q    <= '0;
      rd_to_q      <= 1'b0;
      req_done_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A busy engine (e.g. still initialising) blocks every grant.
          if (!busy && win_vld_d) begin
            grant_idx_q  <= win_idx_d;
            rnw_q        <= reqRnW[win_idx_d];
            data_in_q    <= reqData[{win_idx_d, 3'b000} +: 8];
            toen_q       <= reqTimeOutEn[win_idx_d];
            access_req_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (busy) begin
            access_req_q <= 1'b0;
            state_q      <= WT_BUSY_LO;
          end
        end
        WT_BUSY_LO: begin
          if (!busy) begin
            rd_data_q  <= dataOut;
            rd_to_q    <= timeOut & rnw_q;
            req_done_q <= NUM_REQ'(1) << grant_idx_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          req_done_q <= '0;
          rr_ptr_q   <= grant_idx_q;
`ifdef UART_ARB_LOCK_EN
          if (reqLock[grant_idx_q]) begin
            rr_ptr_q <= lock_ptr_d;
          end
`endif
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqDone       = req_done_q;
  assign rdData        = rd_data_q;
  assign rdTimeOut     = rd_to_q;
  assign grantIdx      = grant_idx_q;
  assign accessReq     = access_req_q;
  assign readNotWrite  = rnw_q;
  assign dataIn        = data_in_q;
  assign timeOutEnable = toen_q;

endmodule
